// File: rtl/rvfi_retire_gen.sv
// rvfi_retire_gen
// ---------------------------------------------------------------------------
// Producer side of the RVFI retirement trace for the PSP core. Each
// instruction that retires in writeback becomes one registered RVFI record
// one cycle later, with a running retirement order, lane-accurate memory
// masks/data, trap/halt flags and constant mode/intr fields.
//
// Handshake: rvfi_valid is a one-cycle pulse per emitted record. There is
// no ready/backpressure; the consumer must take every record in the cycle
// it is presented. When no record is emitted, rvfi_valid is 0 and every
// other rvfi_* output holds the last record.
//
// Ports:
//   clk, reset          core clock, asynchronous active-low reset
//   wb_*                retirement data from the writeback stage
//   rvfi_*              registered RVFI record
//   dbg_halted          1 while the FSM sits in HALTED (no more records)
// ---------------------------------------------------------------------------
module rvfi_retire_gen #(
    parameter int XLEN    = 32,
    parameter int ORDER_W = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_valid,
    input  logic [31:0]        wb_insn,
    input  logic [XLEN-1:0]    wb_pc,
    input  logic [XLEN-1:0]    wb_next_pc,
    input  logic [4:0]         wb_rs1_addr,
    input  logic [4:0]         wb_rs2_addr,
    input  logic [XLEN-1:0]    wb_rs1_rdata,
    input  logic [XLEN-1:0]    wb_rs2_rdata,
    input  logic               wb_rd_we,
    input  logic [4:0]         wb_rd_addr,
    input  logic [XLEN-1:0]    wb_rd_wdata,
    input  logic               wb_mem_read,
    input  logic               wb_mem_write,
    input  logic [2:0]         wb_mem_funct3,
    input  logic [XLEN-1:0]    wb_mem_addr,
    input  logic [XLEN-1:0]    wb_mem_rdata,
    input  logic [XLEN-1:0]    wb_mem_wdata,
    input  logic               wb_trap,
    input  logic               wb_halt,
    output logic               rvfi_valid,
    output logic [ORDER_W-1:0] rvfi_order,
    output logic [31:0]        rvfi_insn,
    output logic               rvfi_trap,
    output logic               rvfi_halt,
    output logic               rvfi_intr,
    output logic [1:0]         rvfi_mode,
    output logic [4:0]         rvfi_rs1_addr,
    output logic [4:0]         rvfi_rs2_addr,
    output logic [4:0]         rvfi_rd_addr,
    output logic [XLEN-1:0]    rvfi_rs1_rdata,
    output logic [XLEN-1:0]    rvfi_rs2_rdata,
    output logic [XLEN-1:0]    rvfi_rd_wdata,
    output logic [XLEN-1:0]    rvfi_pc_rdata,
    output logic [XLEN-1:0]    rvfi_pc_wdata,
    output logic [XLEN-1:0]    rvfi_mem_addr,
    output logic [3:0]         rvfi_mem_rmask,
    output logic [3:0]         rvfi_mem_wmask,
    output logic [XLEN-1:0]    rvfi_mem_rdata,
    output logic [XLEN-1:0]    rvfi_mem_wdata,
    output logic               dbg_halted
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic [ORDER_W-1:0] order;
        logic [31:0]        insn;
        logic               trap;
        logic               halt;
        logic [4:0]         rs1_addr;
        logic [4:0]         rs2_addr;
        logic [4:0]         rd_addr;
        logic [XLEN-1:0]    rs1_rdata;
        logic [XLEN-1:0]    rs2_rdata;
        logic [XLEN-1:0]    rd_wdata;
        logic [XLEN-1:0]    pc_rdata;
        logic [XLEN-1:0]    pc_wdata;
        logic [XLEN-1:0]    mem_addr;
        logic [3:0]         mem_rmask;
        logic [3:0]         mem_wmask;
        logic [XLEN-1:0]    mem_rdata;
        logic [XLEN-1:0]    mem_wdata;
    } rec_t;

    state_t             state_q, state_d;
    logic [ORDER_W-1:0] order_q, order_d;
    logic               valid_q, valid_d;
    rec_t               rec_q, rec_d;

    // Expand a byte-lane mask into a bit mask over the 32-bit bus word.
    function automatic logic [XLEN-1:0] lane_bits(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // ---------------- memory access decode ----------------
    logic [1:0]      mem_off;
    logic [3:0]      mem_base;
    logic [3:0]      mem_mask;
    logic            mem_misal;
    logic            mem_acc;
    logic            mem_bad;
    logic [XLEN-1:0] mem_addr_c;
    logic [3:0]      mem_rmask_c;
    logic [3:0]      mem_wmask_c;
    logic [XLEN-1:0] mem_rdata_c;
    logic [XLEN-1:0] mem_wdata_c;

    always_comb begin
        mem_off     = wb_mem_addr[1:0];
        mem_base    = 4'b0000;
        mem_misal   = 1'b0;
        case (wb_mem_funct3)
            3'b000, 3'b100: mem_base = 4'b0001;
            3'b001, 3'b101: begin
                mem_base  = 4'b0011;
                mem_misal = (mem_off == 2'd3);
            end
            3'b010: begin
                mem_base  = 4'b1111;
                mem_misal = (mem_off != 2'd0);
            end
            // Unsupported size codes are treated like a misaligned access.
            default: mem_misal = 1'b1;
        endcase
        mem_mask    = mem_base << mem_off;
        mem_acc     = wb_mem_read | wb_mem_write;
        // A simultaneous load+store or a bad size/alignment traps and
        // reports no lanes; the aligned address is still shown.
        mem_bad     = mem_acc & (mem_misal | (wb_mem_read & wb_mem_write));
        mem_addr_c  = '0;
        mem_rmask_c = 4'b0000;
        mem_wmask_c = 4'b0000;
        mem_rdata_c = '0;
        mem_wdata_c = '0;
        if (mem_acc) begin
            mem_addr_c = {wb_mem_addr[XLEN-1:2], 2'b00};
            if (!mem_bad && wb_mem_read) begin
                mem_rmask_c = mem_mask;
                mem_rdata_c = wb_mem_rdata & lane_bits(mem_mask);
            end
            if (!mem_bad && wb_mem_write) begin
                // Store data arrives unshifted (rs2); move it onto its lanes.
                mem_wmask_c = mem_mask;
                mem_wdata_c = (wb_mem_wdata << {mem_off, 3'b000}) & lane_bits(mem_mask);
            end
        end
    end

    // ---------------- FSM next state and record build ----------------
    always_comb begin
        state_d = state_q;
        order_d = order_q;
        valid_d = 1'b0;
        rec_d   = rec_q;
        if (wb_valid && (state_q == ST_RUN)) begin
            valid_d        = 1'b1;
            rec_d.order    = order_q;
            order_d        = order_q + {{(ORDER_W-1){1'b0}}, 1'b1};
            rec_d.insn     = wb_insn;
            rec_d.trap     = wb_trap | mem_bad;
            rec_d.halt     = wb_halt;
            rec_d.rs1_addr = wb_rs1_addr;
            rec_d.rs2_addr = wb_rs2_addr;
            rec_d.rs1_rdata = (wb_rs1_addr == 5'd0) ? '0 : wb_rs1_rdata;
            rec_d.rs2_rdata = (wb_rs2_addr == 5'd0) ? '0 : wb_rs2_rdata;
            if (wb_rd_we && (wb_rd_addr != 5'd0)) begin
                rec_d.rd_addr  = wb_rd_addr;
                rec_d.rd_wdata = wb_rd_wdata;
            end else begin
                rec_d.rd_addr  = 5'd0;
                rec_d.rd_wdata = '0;
            end
            rec_d.pc_rdata  = wb_pc;
            rec_d.pc_wdata  = wb_next_pc;
            rec_d.mem_addr  = mem_addr_c;
            rec_d.mem_rmask = mem_rmask_c;
            rec_d.mem_wmask = mem_wmask_c;
            rec_d.mem_rdata = mem_rdata_c;
            rec_d.mem_wdata = mem_wdata_c;
            // The halting record itself is still emitted.
            if (wb_halt) begin
                state_d = ST_HALTED;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            order_q <= '0;
            valid_q <= 1'b0;
            rec_q   <= '0;
        end else begin
            state_q <= state_d;
            order_q <= order_d;
            valid_q <= valid_d;
            rec_q   <= rec_d;
        end
    end

    assign rvfi_valid     = valid_q;
    assign rvfi_order     = rec_q.order;
    assign rvfi_insn      = rec_q.insn;
    assign rvfi_trap      = rec_q.trap;
    assign rvfi_halt      = rec_q.halt;
    assign rvfi_intr      = 1'b0;
    assign rvfi_mode      = 2'b11;
    assign rvfi_rs1_addr  = rec_q.rs1_addr;
    assign rvfi_rs2_addr  = rec_q.rs2_addr;
    assign rvfi_rd_addr   = rec_q.rd_addr;
    assign rvfi_rs1_rdata = rec_q.rs1_rdata;
    assign rvfi_rs2_rdata = rec_q.rs2_rdata;
    assign rvfi_rd_wdata  = rec_q.rd_wdata;
    assign rvfi_pc_rdata  = rec_q.pc_rdata;
    assign rvfi_pc_wdata  = rec_q.pc_wdata;
    assign rvfi_mem_addr  = rec_q.mem_addr;
    assign rvfi_mem_rmask = rec_q.mem_rmask;
    assign rvfi_mem_wmask = rec_q.mem_wmask;
    assign rvfi_mem_rdata = rec_q.mem_rdata;
    assign rvfi_mem_wdata = rec_q.mem_wdata;
    assign dbg_halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_rvfi_retire_gen.sv
// Bench for rvfi_retire_gen: directed vector table, halt and async-reset
// sequences, then randomized retirements checked against a record-level
// reference model through an expected-record queue.
module tb_rvfi_retire_gen;
    localparam int OW = 5;  // small order counter so wrap-around is reached

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          wb_valid;
    logic [31:0]   wb_insn, wb_pc, wb_next_pc;
    logic [4:0]    wb_rs1_addr, wb_rs2_addr, wb_rd_addr;
    logic [31:0]   wb_rs1_rdata, wb_rs2_rdata, wb_rd_wdata;
    logic          wb_rd_we, wb_mem_read, wb_mem_write, wb_trap, wb_halt;
    logic [2:0]    wb_mem_funct3;
    logic [31:0]   wb_mem_addr, wb_mem_rdata, wb_mem_wdata;
    logic          rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr, dbg_halted;
    logic [OW-1:0] rvfi_order;
    logic [31:0]   rvfi_insn;
    logic [1:0]    rvfi_mode;
    logic [4:0]    rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [31:0]   rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0]   rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr;
    logic [3:0]    rvfi_mem_rmask, rvfi_mem_wmask;
    logic [31:0]   rvfi_mem_rdata, rvfi_mem_wdata;

    rvfi_retire_gen #(.XLEN(32), .ORDER_W(OW)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_insn(wb_insn),
        .wb_pc(wb_pc), .wb_next_pc(wb_next_pc),
        .wb_rs1_addr(wb_rs1_addr), .wb_rs2_addr(wb_rs2_addr),
        .wb_rs1_rdata(wb_rs1_rdata), .wb_rs2_rdata(wb_rs2_rdata),
        .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata),
        .wb_mem_read(wb_mem_read), .wb_mem_write(wb_mem_write),
        .wb_mem_funct3(wb_mem_funct3), .wb_mem_addr(wb_mem_addr),
        .wb_mem_rdata(wb_mem_rdata), .wb_mem_wdata(wb_mem_wdata),
        .wb_trap(wb_trap), .wb_halt(wb_halt),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_mode(rvfi_mode), .rvfi_rs1_addr(rvfi_rs1_addr),
        .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_pc_rdata(rvfi_pc_rdata),
        .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .dbg_halted(dbg_halted)
    );

    // ---------------- types ----------------
    typedef struct packed {
        logic [31:0] insn, pc, npc;
        logic [4:0]  rs1a, rs2a;
        logic [31:0] rs1d, rs2d;
        logic        rd_we;
        logic [4:0]  rda;
        logic [31:0] rdd;
        logic        mr, mw;
        logic [2:0]  f3;
        logic [31:0] maddr, mrdata, mwdata;
        logic        trap, halt;
    } wb_t;

    typedef struct packed {
        logic [OW-1:0] order;
        logic [31:0]   insn;
        logic          trap, halt;
        logic [4:0]    rs1a, rs2a, rda;
        logic [31:0]   rs1d, rs2d, rdd, pcr, pcw, maddr;
        logic [3:0]    rmask, wmask;
        logic [31:0]   mrdata, mwdata;
    } rec_t;

    typedef struct packed {
        logic [OW-1:0] order;
        logic [31:0]   pcw;
        logic [4:0]    rda;
        logic [31:0]   rdd, rs1d, maddr;
        logic [3:0]    rmask;
        logic [31:0]   mrdata;
        logic [3:0]    wmask;
        logic [31:0]   mwdata;
        logic          trap;
    } exp_t;

    typedef struct packed {
        wb_t  w;
        exp_t e;
    } vec_t;

    localparam int RW = $bits(rec_t);

    // ---------------- scoreboard state ----------------
    logic [RW-1:0] exp_q[$];
    rec_t          last_rec;
    int            m_order;
    bit            m_halted;
    int            n_chk = 0;
    int            n_err = 0;

    task automatic check_val(string name, logic [383:0] act, logic [383:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t act_rec();
        rec_t r;
        r.order = rvfi_order;       r.insn = rvfi_insn;
        r.trap = rvfi_trap;         r.halt = rvfi_halt;
        r.rs1a = rvfi_rs1_addr;     r.rs2a = rvfi_rs2_addr;  r.rda = rvfi_rd_addr;
        r.rs1d = rvfi_rs1_rdata;    r.rs2d = rvfi_rs2_rdata; r.rdd = rvfi_rd_wdata;
        r.pcr = rvfi_pc_rdata;      r.pcw = rvfi_pc_wdata;   r.maddr = rvfi_mem_addr;
        r.rmask = rvfi_mem_rmask;   r.wmask = rvfi_mem_wmask;
        r.mrdata = rvfi_mem_rdata;  r.mwdata = rvfi_mem_wdata;
        return r;
    endfunction

    // Reference model: builds the record from the retirement rules using
    // byte-granular arithmetic (access size in bytes, lane ranges).
    function automatic rec_t model(wb_t w, int ord);
        rec_t r;
        int   off, nb;
        bit   acc, bad;
        r = '0;
        r.order = OW'(ord);
        r.insn  = w.insn;
        r.halt  = w.halt;
        r.rs1a  = w.rs1a;
        r.rs2a  = w.rs2a;
        r.rs1d  = (w.rs1a == 0) ? 32'd0 : w.rs1d;
        r.rs2d  = (w.rs2a == 0) ? 32'd0 : w.rs2d;
        if (w.rd_we && w.rda != 0) begin
            r.rda = w.rda;
            r.rdd = w.rdd;
        end
        r.pcr = w.pc;
        r.pcw = w.npc;
        off = int'(w.maddr % 4);
        case (w.f3)
            3'd0, 3'd4: nb = 1;
            3'd1, 3'd5: nb = 2;
            3'd2:       nb = 4;
            default:    nb = 0;
        endcase
        acc = w.mr || w.mw;
        bad = acc && ((w.mr && w.mw) || nb == 0 || off + nb > 4);
        if (acc) r.maddr = w.maddr - 32'(off);
        if (acc && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (b >= off && b < off + nb) begin
                    if (w.mr) begin
                        r.rmask[b] = 1'b1;
                        r.mrdata[8*b +: 8] = w.mrdata[8*b +: 8];
                    end
                    if (w.mw) begin
                        r.wmask[b] = 1'b1;
                        r.mwdata[8*b +: 8] = w.mwdata[8*(b-off) +: 8];
                    end
                end
            end
        end
        r.trap = w.trap || bad;
        return r;
    endfunction

    // Per-cycle check: valid against the queue, record against the popped
    // entry, or against the previous record while no record is expected.
    task automatic check_cycle();
        logic v_exp;
        rec_t e;
        v_exp = (exp_q.size() > 0);
        check_val("valid", rvfi_valid, v_exp);
        if (v_exp) begin
            e = exp_q.pop_front();
            last_rec = e;
        end else begin
            e = last_rec;
        end
        check_val(v_exp ? "record" : "hold", act_rec(), e);
        check_val("mode_intr", {rvfi_mode, rvfi_intr}, 3'b110);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(wb_t w, logic v);
        wb_valid = v;            wb_insn = w.insn;
        wb_pc = w.pc;            wb_next_pc = w.npc;
        wb_rs1_addr = w.rs1a;    wb_rs2_addr = w.rs2a;
        wb_rs1_rdata = w.rs1d;   wb_rs2_rdata = w.rs2d;
        wb_rd_we = w.rd_we;      wb_rd_addr = w.rda;     wb_rd_wdata = w.rdd;
        wb_mem_read = w.mr;      wb_mem_write = w.mw;    wb_mem_funct3 = w.f3;
        wb_mem_addr = w.maddr;   wb_mem_rdata = w.mrdata; wb_mem_wdata = w.mwdata;
        wb_trap = w.trap;        wb_halt = w.halt;
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic step(wb_t w, logic v);
        drive(w, v);
        @(posedge clk);
        if (v && !m_halted) begin
            exp_q.push_back(model(w, m_order));
            m_order = (m_order + 1) % (1 << OW);
            if (w.halt) m_halted = 1'b1;
        end
        @(negedge clk);
        check_cycle();
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_rec = '0;
        m_order  = 0;
        m_halted = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive('0, 1'b0);
        #1;
        check_val("rst_valid", rvfi_valid, 1'b0);
        check_val("rst_record", act_rec(), rec_t'('0));
        check_val("rst_mode_intr", {rvfi_mode, rvfi_intr}, 3'b110);
        check_val("rst_halted", dbg_halted, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic wb_t mk(logic [31:0] pc, logic [4:0] rs1a, logic [31:0] rs1d,
                               logic rd_we, logic [4:0] rda, logic [31:0] rdd,
                               logic mr, logic mw, logic [2:0] f3, logic [31:0] addr,
                               logic [31:0] mrd, logic [31:0] mwd, logic trap);
        wb_t w;
        w = '0;
        w.insn = {pc[15:0], 16'h0093};
        w.pc = pc;           w.npc = pc + 32'd4;
        w.rs1a = rs1a;       w.rs1d = rs1d;
        w.rs2a = pc[6:2];    w.rs2d = 32'h22 + pc;
        w.rd_we = rd_we;     w.rda = rda;     w.rdd = rdd;
        w.mr = mr;           w.mw = mw;       w.f3 = f3;
        w.maddr = addr;      w.mrdata = mrd;  w.mwdata = mwd;
        w.trap = trap;
        return w;
    endfunction

    function automatic exp_t mke(int ord, logic [31:0] pcw, logic [4:0] rda, logic [31:0] rdd,
                                 logic [31:0] rs1d, logic [31:0] maddr, logic [3:0] rmask,
                                 logic [31:0] mrdata, logic [3:0] wmask, logic [31:0] mwdata,
                                 logic trap);
        exp_t e;
        e.order = OW'(ord); e.pcw = pcw;     e.rda = rda;       e.rdd = rdd;
        e.rs1d = rs1d;      e.maddr = maddr; e.rmask = rmask;   e.mrdata = mrdata;
        e.wmask = wmask;    e.mwdata = mwdata; e.trap = trap;
        return e;
    endfunction

    function automatic wb_t rand_wb();
        wb_t w;
        int  sel;
        w.insn = $urandom;   w.pc = $urandom;   w.npc = $urandom;
        w.rs1a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        w.rs2a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        w.rs1d = $urandom;   w.rs2d = $urandom;
        w.rd_we = 1'($urandom);
        w.rda = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        w.rdd = $urandom;
        sel = $urandom_range(0, 6);
        w.mr = (sel == 1 || sel == 2 || sel == 5);
        w.mw = (sel == 3 || sel == 4 || sel == 5);
        w.f3 = 3'($urandom_range(0, 7));
        w.maddr = $urandom;  w.mrdata = $urandom;  w.mwdata = $urandom;
        w.trap = ($urandom_range(0, 9) == 0);
        w.halt = 1'b0;
        return w;
    endfunction

    // ---------------- test ----------------
    vec_t tbl[14];

    initial begin
        exp_t a;
        wb_t  w;
        reset = 1'b0;
        drive('0, 1'b0);
        model_reset();

        //                pc     rs1a rs1d        we rda rdd           mr mw f3 addr          mrd           mwd           trap
        tbl[0].w  = mk(32'h00, 0, 32'h55,   1, 1, 32'h1,        0, 0, 0, 32'h0,       32'h0,        32'h0,        0);
        tbl[1].w  = mk(32'h04, 1, 32'h1,    1, 1, 32'h2,        0, 0, 0, 32'h0,       32'h0,        32'h0,        0);
        tbl[2].w  = mk(32'h08, 1, 32'h2,    1, 1, 32'h3,        0, 0, 0, 32'h0,       32'h0,        32'h0,        0);
        tbl[3].w  = mk(32'h0C, 2, 32'h1000, 1, 3, 32'hFFFFFFBB, 1, 0, 0, 32'h1002,    32'hAABBCCDD, 32'h0,        0);
        tbl[4].w  = mk(32'h10, 2, 32'h2000, 0, 0, 32'h0,        0, 1, 1, 32'h2002,    32'h0,        32'h0000BEEF, 0);
        tbl[5].w  = mk(32'h14, 2, 32'h2000, 0, 0, 32'h0,        0, 1, 2, 32'h2001,    32'h0,        32'h11223344, 0);
        tbl[6].w  = mk(32'h18, 0, 32'h55,   1, 0, 32'h1234,     0, 0, 0, 32'h0,       32'h0,        32'h0,        0);
        tbl[7].w  = mk(32'h1C, 3, 32'h3000, 1, 4, 32'h99,       1, 0, 5, 32'h3003,    32'hDEADBEEF, 32'h0,        0);
        tbl[8].w  = mk(32'h20, 3, 32'h4000, 1, 5, 32'h12345678, 1, 0, 2, 32'h4000,    32'h12345678, 32'h0,        0);
        tbl[9].w  = mk(32'h24, 3, 32'h5000, 0, 0, 32'h0,        1, 1, 2, 32'h5000,    32'hCAFEF00D, 32'h1,        0);
        tbl[10].w = mk(32'h28, 3, 32'h6000, 0, 0, 32'h0,        0, 1, 3, 32'h6000,    32'h0,        32'h77,       0);
        tbl[11].w = mk(32'h2C, 7, 32'h70,   0, 5, 32'h77,       0, 0, 0, 32'h0,       32'h0,        32'h0,        1);
        tbl[12].w = mk(32'h30, 3, 32'h5000, 0, 0, 32'h0,        0, 1, 0, 32'h5003,    32'h0,        32'h123456A5, 0);
        tbl[13].w = mk(32'h34, 3, 32'h5000, 1, 6, 32'hFFFF8899, 1, 0, 1, 32'h5002,    32'h88997766, 32'h0,        0);
        //                ord pcw    rda rdd           rs1d      maddr     rmask    mrdata        wmask    mwdata        trap
        tbl[0].e  = mke(0,  32'h04, 1, 32'h1,        32'h0,    32'h0,    4'b0000, 32'h0,        4'b0000, 32'h0,        0);
        tbl[1].e  = mke(1,  32'h08, 1, 32'h2,        32'h1,    32'h0,    4'b0000, 32'h0,        4'b0000, 32'h0,        0);
        tbl[2].e  = mke(2,  32'h0C, 1, 32'h3,        32'h2,    32'h0,    4'b0000, 32'h0,        4'b0000, 32'h0,        0);
        tbl[3].e  = mke(3,  32'h10, 3, 32'hFFFFFFBB, 32'h1000, 32'h1000, 4'b0100, 32'h00BB0000, 4'b0000, 32'h0,        0);
        tbl[4].e  = mke(4,  32'h14, 0, 32'h0,        32'h2000, 32'h2000, 4'b0000, 32'h0,        4'b1100, 32'hBEEF0000, 0);
        tbl[5].e  = mke(5,  32'h18, 0, 32'h0,        32'h2000, 32'h2000, 4'b0000, 32'h0,        4'b0000, 32'h0,        1);
        tbl[6].e  = mke(6,  32'h1C, 0, 32'h0,        32'h0,    32'h0,    4'b0000, 32'h0,        4'b0000, 32'h0,        0);
        tbl[7].e  = mke(7,  32'h20, 4, 32'h99,       32'h3000, 32'h3000, 4'b0000, 32'h0,        4'b0000, 32'h0,        1);
        tbl[8].e  = mke(8,  32'h24, 5, 32'h12345678, 32'h4000, 32'h4000, 4'b1111, 32'h12345678, 4'b0000, 32'h0,        0);
        tbl[9].e  = mke(9,  32'h28, 0, 32'h0,        32'h5000, 32'h5000, 4'b0000, 32'h0,        4'b0000, 32'h0,        1);
        tbl[10].e = mke(10, 32'h2C, 0, 32'h0,        32'h6000, 32'h6000, 4'b0000, 32'h0,        4'b0000, 32'h0,        1);
        tbl[11].e = mke(11, 32'h30, 0, 32'h0,        32'h70,   32'h0,    4'b0000, 32'h0,        4'b0000, 32'h0,        1);
        tbl[12].e = mke(12, 32'h34, 0, 32'h0,        32'h5000, 32'h5000, 4'b0000, 32'h0,        4'b1000, 32'hA5000000, 0);
        tbl[13].e = mke(13, 32'h38, 6, 32'hFFFF8899, 32'h5000, 32'h5000, 4'b1100, 32'h88990000, 4'b0000, 32'h0,        0);

        @(negedge clk);
        do_reset();

        // Directed vectors, retired back to back.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].w, 1'b1);
            a = mke(int'(rvfi_order), rvfi_pc_wdata, rvfi_rd_addr, rvfi_rd_wdata, rvfi_rs1_rdata,
                    rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_rdata, rvfi_mem_wmask,
                    rvfi_mem_wdata, rvfi_trap);
            check_val($sformatf("vec%0d", i), a, tbl[i].e);
        end
        step('0, 1'b0);
        check_val("idle_valid", rvfi_valid, 1'b0);

        // Halt: record at order 5 is emitted, later retirements ignored.
        do_reset();
        for (int i = 0; i < 5; i++) step(mk(32'(4*i), 1, 32'(i), 1, 2, 32'(i), 0, 0, 0, 0, 0, 0, 0), 1'b1);
        w = mk(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        w.halt = 1'b1;
        step(w, 1'b0);  // halt without valid has no effect
        check_val("halt_noval_state", dbg_halted, 1'b0);
        step(w, 1'b1);
        check_val("halt_rec", {rvfi_valid, rvfi_halt, rvfi_order}, {2'b11, OW'(5)});
        check_val("halt_state", dbg_halted, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(mk(32'h200 + 32'(4*i), 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1);
            check_val("halted_quiet", {rvfi_valid, rvfi_order}, {1'b0, OW'(5)});
        end
        do_reset();
        step(mk(32'h300, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        check_val("order_after_reset", {rvfi_valid, rvfi_order}, {1'b1, OW'(0)});

        // Asynchronous reset in the middle of a valid pulse.
        step(mk(32'h304, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        step(mk(32'h308, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        check_val("pre_async", {rvfi_valid, rvfi_order}, {1'b1, OW'(2)});
        #2 reset = 1'b0;
        #1;
        check_val("async_rst", {rvfi_valid, rvfi_order, rvfi_mode}, {1'b1 ^ 1'b1, OW'(0), 2'b11});
        @(negedge clk);
        do_reset();

        // Randomized retirements; first chunk has no halts so the order wraps.
        for (int c = 0; c < 4; c++) begin
            do_reset();
            for (int k = 0; k < 80; k++) begin
                w = rand_wb();
                if (c != 0) w.halt = ($urandom_range(0, 39) == 0);
                step(w, $urandom_range(0, 9) < 7);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/rvfi_retire_gen.md
Name: rvfi_retire_gen

Overview:
- Producer side of the RVFI retirement-trace interface for the PSP core.
- Takes per-instruction retirement data from the writeback stage and emits one registered, RVFI-compliant record per retired instruction.
- Generates `rvfi_order`, lane-accurate memory masks and data, trap/halt flags and constant mode/intr fields, so the formal monitor can be driven straight from the core.
- Replaces ad-hoc order counting in benches.

Parameters:
XLEN, 32, data/address width (only 32 supported)
ORDER_W, 64, width of the retirement order counter

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
wb_valid  in  1  instruction retires this cycle
wb_insn  in  32  retired instruction word
wb_pc  in  XLEN  PC of retired instruction
wb_next_pc  in  XLEN  PC of next instruction
wb_rs1_addr, wb_rs2_addr  in  5  source register indices
wb_rs1_rdata, wb_rs2_rdata  in  XLEN  source operand values
wb_rd_we  in  1  register write enable
wb_rd_addr  in  5  destination index
wb_rd_wdata  in  XLEN  writeback value
wb_mem_read, wb_mem_write  in  1  load / store retired
wb_mem_funct3  in  3  load/store size code
wb_mem_addr  in  XLEN  byte address of access
wb_mem_rdata  in  XLEN  raw aligned bus word returned
wb_mem_wdata  in  XLEN  unshifted store source value (rs2)
wb_trap, wb_halt  in  1  core-reported trap / halt
rvfi_valid  out  1  record valid (one-cycle pulse per retirement)
rvfi_order  out  ORDER_W  retirement index
rvfi_insn  out  32
rvfi_trap, rvfi_halt, rvfi_intr  out  1
rvfi_mode  out  2
rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  out  5
rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  out  XLEN
rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr  out  XLEN
rvfi_mem_rmask, rvfi_mem_wmask  out  4
rvfi_mem_rdata, rvfi_mem_wdata  out  XLEN

Behaviour:
- Reset (reset==0, async):
  - All outputs 0, except `rvfi_mode`=2'b11.
  - Internal order counter = 0; FSM = RUN.
  - Asserting reset mid-pulse drops `rvfi_valid` immediately.
- Latency: `wb_valid` sampled at edge N produces `rvfi_valid`=1 for exactly the cycle after edge N.
  - Back-to-back retirements give consecutive valid cycles.
  - No backpressure.
- When no record is emitted: `rvfi_valid`=0 and all other outputs hold their last values.
- Order:
  - `rvfi_order` = number of records emitted before this one; the first record after reset is 0.
  - Counter increments once per emitted record, trapped records included.
  - Wraps modulo 2^ORDER_W.
- Passthrough: insn, pc_rdata←wb_pc, pc_wdata←wb_next_pc, rs addrs.
- Source data: rs1/rs2 rdata forced 0 when the corresponding addr==0.
- Destination:
  - If `wb_rd_we`==0 or `wb_rd_addr`==0: `rvfi_rd_addr`=0 and `rvfi_rd_wdata`=0.
  - Otherwise both pass through.
- Memory: off = `wb_mem_addr[1:0]`; `rvfi_mem_addr` = `wb_mem_addr` with bits[1:0] cleared.
  - Base mask by funct3: 000/100 → 4'b0001; 001/101 → 4'b0011; 010 → 4'b1111; any other code → illegal.
  - Mask = base << off.
  - Misaligned when: halfword with off==3, word with off!=0, or illegal code.
  - Load: rmask=mask; rdata = `wb_mem_rdata` with lanes outside rmask zeroed.
  - Store: wmask=mask; wdata = (`wb_mem_wdata` << 8*off) with lanes outside wmask zeroed.
  - Neither read nor write: masks 0, mem addr/rdata/wdata 0.
  - Both read and write, or misaligned: masks 0, mem data 0, record trap=1.
- Flags: `rvfi_trap` = wb_trap | misaligned | (read & write); `rvfi_halt`=wb_halt; `rvfi_intr`=0; `rvfi_mode`=2'b11.
- FSM:
  - RUN → HALTED on emitting a record with halt=1; that record is still emitted.
  - In HALTED, `wb_valid` is ignored: no further records, order frozen.
  - HALTED exits only via reset.
  - `wb_valid`=0 with `wb_halt`=1 has no effect.

Test Plan:
- Reset release, then 3 consecutive `wb_valid` ADDIs (pc 0x0,0x4,0x8) → `rvfi_valid` high for 3 cycles starting 1 cycle later; order 0,1,2; pc_wdata 0x4,0x8,0xC.
- LB at addr 0x1002, bus word 0xAABBCCDD → mem_addr 0x1000, rmask 4'b0100, rdata 0x00BB0000, wmask 0, trap 0.
- SH of 0x0000BEEF at addr 0x2002 → wmask 4'b1100, wdata 0xBEEF0000. Then SW at 0x2001 → trap 1, masks 0, order still increments.
- Instruction with rd_addr 0, rd_we 1, rd_wdata 0x1234 → `rvfi_rd_addr`=0, `rvfi_rd_wdata`=0. rs1_addr 0 with rs1_rdata 0x55 → `rvfi_rs1_rdata`=0.
- Record with `wb_halt`=1 (order 5), then 4 more `wb_valid` pulses → only the halt record emitted (halt=1, order 5), no further `rvfi_valid`. After reset pulse, next record has order 0.
- Drive reset low asynchronously between edges while `rvfi_valid`=1 → `rvfi_valid` and `rvfi_order` go 0 before the next clock edge; `rvfi_mode` reads 2'b11.
